// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-TX-side signals of the TX arbiter, grouped as one bundle.
// The arbiter uses the slave modport; the environment driving it uses master.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_W       = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          transmit;
    logic [DATA_WIDTH-1:0]         tx_byte;
    logic                          tx_fifo_full;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;
    logic                          timeout_irq;
    logic [ID_W-1:0]               timeout_id;

    modport master (
        output req_valid, req_data, req_last, tx_fifo_full,
        input  req_ready, transmit, tx_byte, grant, busy, timeout_irq, timeout_id
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_fifo_full,
        output req_ready, transmit, tx_byte, grant, busy, timeout_irq, timeout_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one UART TX push port between NUM_REQ
// byte streams, with a stall watchdog that revokes a silent owner's grant.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int STALL_TIMEOUT = 1024,
    parameter int ID_W          = 2
) (
    input logic               clk,
    input logic               rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(STALL_TIMEOUT) + 1;

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t              state;
    logic [ID_W-1:0]     owner_idx;
    logic [ID_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]    stall_cnt;
    logic [NUM_REQ-1:0]  grant_r;
    logic                busy_r;
    logic                irq_r;
    logic [ID_W-1:0]     irq_id_r;

    logic [NUM_REQ-1:0]    req_ready_c;
    logic                  transmit_c;
    logic [DATA_WIDTH-1:0] tx_byte_c;
    logic                  owner_valid;
    logic                  owner_last;
    logic [DATA_WIDTH-1:0] owner_data;
    logic [ID_W-1:0]       pick_idx;

    // First valid requester at or above ptr, wrapping; the previous owner sits last.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] pick;
        int              k;
        pick = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (v[k]) pick = ID_W'(k);
        end
        return pick;
    endfunction

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
        return ID_W'((int'(g) + 1) % NUM_REQ);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    assign owner_valid = bus.req_valid[owner_idx];
    assign owner_last  = bus.req_last[owner_idx];
    assign owner_data  = bus.req_data[owner_idx*DATA_WIDTH +: DATA_WIDTH];
    assign pick_idx    = rr_pick(bus.req_valid, rr_ptr);

    // Push path is combinational so the owner's byte lands in the FIFO the same cycle.
    always_comb begin
        req_ready_c = '0;
        transmit_c  = 1'b0;
        tx_byte_c   = '0;
        if (state == GRANTED) begin
            req_ready_c[owner_idx] = ~bus.tx_fifo_full;
            transmit_c             = owner_valid & ~bus.tx_fifo_full;
            if (transmit_c) tx_byte_c = owner_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_idx <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
            grant_r   <= '0;
            busy_r    <= 1'b0;
            irq_r     <= 1'b0;
            irq_id_r  <= '0;
        end else begin
            irq_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        owner_idx <= pick_idx;
                        grant_r   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        busy_r    <= 1'b1;
                        stall_cnt <= '0;
                        state     <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (transmit_c) begin
                        stall_cnt <= '0;
                        if (owner_last) begin
                            state   <= IDLE;
                            grant_r <= '0;
                            busy_r  <= 1'b0;
                            rr_ptr  <= next_ptr(owner_idx);
                        end
                    end else if (!owner_valid) begin
                        // Silence only counts when the owner has nothing to offer;
                        // a valid byte blocked by a full FIFO holds the count.
                        if (stall_cnt == CNT_W'(STALL_TIMEOUT - 1)) begin
                            state    <= IDLE;
                            grant_r  <= '0;
                            busy_r   <= 1'b0;
                            rr_ptr   <= next_ptr(owner_idx);
                            irq_r    <= 1'b1;
                            irq_id_r <= owner_idx;
                        end else begin
                            stall_cnt <= sat_inc(stall_cnt);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.transmit    = transmit_c;
    assign bus.tx_byte     = tx_byte_c;
    assign bus.grant       = grant_r;
    assign bus.busy        = busy_r;
    assign bus.timeout_irq = irq_r;
    assign bus.timeout_id  = irq_id_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: basic packet, backpressure, watchdog,
// mid-packet reset, round-robin ordering and fairness under random FIFO-full.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int ST = 1024;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_W(IW)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .STALL_TIMEOUT(ST), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    // Packet tables for the traffic driver: per-requester byte lists and a log of pushes.
    logic [DW-1:0] p_data [NR][16];
    logic          p_last [NR][16];
    int            p_cnt  [NR];
    int            p_idx  [NR];
    int            log_cyc   [64];
    logic [DW-1:0] log_byte  [64];
    logic [NR-1:0] log_grant [64];
    int            log_n;
    int            viol;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid    = '0;
        bus.req_data     = '0;
        bus.req_last     = '0;
        bus.tx_fifo_full = 1'b0;
    endtask

    task automatic set_req(input int r, input logic v, input logic [DW-1:0] d, input logic l);
        bus.req_valid[r]        = v;
        bus.req_data[r*DW +: DW] = d;
        bus.req_last[r]         = l;
    endtask

    task automatic run_traffic(input int ncyc, input bit rand_full);
        log_n = 0;
        viol  = 0;
        for (int c = 0; c < ncyc; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (p_idx[r] < p_cnt[r]) set_req(r, 1'b1, p_data[r][p_idx[r]], p_last[r][p_idx[r]]);
                else                     set_req(r, 1'b0, '0, 1'b0);
            end
            bus.tx_fifo_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (bus.transmit && bus.tx_fifo_full) viol++;
            if (bus.transmit && log_n < 64) begin
                log_cyc[log_n]   = c;
                log_byte[log_n]  = bus.tx_byte;
                log_grant[log_n] = bus.grant;
                log_n++;
            end
            for (int r = 0; r < NR; r++)
                if (bus.req_valid[r] && bus.req_ready[r]) p_idx[r]++;
            nxt();
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        nxt(); nxt(); nxt();
        @(negedge clk);
        checks++; if (bus.grant !== 4'b0000) $display("FAIL reset_grant got=%b exp=0000", bus.grant); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
        checks++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); else passed++;
        checks++; if (bus.transmit !== 1'b0 || bus.tx_byte !== 8'h00) $display("FAIL reset_tx got=%b/%h exp=0/00", bus.transmit, bus.tx_byte); else passed++;
        checks++; if (bus.timeout_irq !== 1'b0 || bus.timeout_id !== 2'd0) $display("FAIL reset_irq got=%b/%0d exp=0/0", bus.timeout_irq, bus.timeout_id); else passed++;
    endtask

    task automatic test_basic_packet();
        logic [DW-1:0] bytes [3];
        bytes[0] = 8'hA1; bytes[1] = 8'hA2; bytes[2] = 8'hA3;
        nxt();
        rst = 1'b0;
        set_req(1, 1'b1, bytes[0], 1'b0);
        @(negedge clk);
        checks++; if (bus.grant !== 4'b0000 || bus.transmit !== 1'b0) $display("FAIL basic_arb_cycle got=%b/%b exp=0000/0", bus.grant, bus.transmit); else passed++;
        for (int i = 0; i < 3; i++) begin
            nxt();
            set_req(1, 1'b1, bytes[i], (i == 2));
            @(negedge clk);
            checks++;
            if (bus.grant !== 4'b0010 || bus.transmit !== 1'b1 || bus.tx_byte !== bytes[i] || bus.req_ready !== 4'b0010)
                $display("FAIL basic_byte%0d got=grant %b tx %b byte %h ready %b exp=0010/1/%h/0010",
                         i, bus.grant, bus.transmit, bus.tx_byte, bus.req_ready, bytes[i]);
            else passed++;
        end
        nxt();
        clear_inputs();
        @(negedge clk);
        checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) $display("FAIL basic_release got=%b/%b exp=0000/0", bus.grant, bus.busy); else passed++;
    endtask

    task automatic test_fifo_full();
        int tx_hi, rdy_hi, irq_hi;
        nxt();
        set_req(3, 1'b1, 8'h30, 1'b0);
        nxt();
        @(negedge clk);
        checks++; if (bus.transmit !== 1'b1 || bus.tx_byte !== 8'h30) $display("FAIL full_first got=%b/%h exp=1/30", bus.transmit, bus.tx_byte); else passed++;
        nxt();
        set_req(3, 1'b1, 8'h31, 1'b0);
        bus.tx_fifo_full = 1'b1;
        tx_hi = 0; rdy_hi = 0; irq_hi = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (bus.transmit) tx_hi++;
            if (bus.req_ready != 4'b0000) rdy_hi++;
            if (bus.timeout_irq) irq_hi++;
            nxt();
        end
        checks++; if (tx_hi !== 0) $display("FAIL full_transmit got=%0d exp=0", tx_hi); else passed++;
        checks++; if (rdy_hi !== 0) $display("FAIL full_ready got=%0d exp=0", rdy_hi); else passed++;
        checks++; if (irq_hi !== 0) $display("FAIL full_irq got=%0d exp=0", irq_hi); else passed++;
        bus.tx_fifo_full = 1'b0;
        @(negedge clk);
        checks++; if (bus.grant !== 4'b1000 || bus.transmit !== 1'b1 || bus.tx_byte !== 8'h31) $display("FAIL full_resume got=%b/%b/%h exp=1000/1/31", bus.grant, bus.transmit, bus.tx_byte); else passed++;
        nxt();
        set_req(3, 1'b1, 8'h32, 1'b1);
        nxt();
        clear_inputs();
        @(negedge clk);
        checks++; if (bus.grant !== 4'b0000) $display("FAIL full_release got=%b exp=0000", bus.grant); else passed++;
    endtask

    task automatic test_stall_timeout();
        int irq_at;
        logic [NR-1:0] grant_before;
        nxt();
        set_req(2, 1'b1, 8'h55, 1'b0);
        nxt();
        @(negedge clk);
        checks++; if (bus.transmit !== 1'b1 || bus.tx_byte !== 8'h55) $display("FAIL stall_accept got=%b/%h exp=1/55", bus.transmit, bus.tx_byte); else passed++;
        nxt();
        clear_inputs();
        irq_at = -1;
        grant_before = '0;
        // Counting samples after the accepting cycle: the irq is set by the
        // STALL_TIMEOUT-th edge after acceptance, so it is seen at sample ST+1.
        for (int k = 1; k <= ST + 20; k++) begin
            @(negedge clk);
            if (bus.timeout_irq) begin
                irq_at = k;
                break;
            end
            grant_before = bus.grant;
            nxt();
        end
        checks++; if (irq_at !== ST + 1) $display("FAIL stall_irq_time got=%0d exp=%0d", irq_at, ST + 1); else passed++;
        checks++; if (grant_before !== 4'b0100) $display("FAIL stall_grant_held got=%b exp=0100", grant_before); else passed++;
        checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) $display("FAIL stall_revoke got=%b/%b exp=0000/0", bus.grant, bus.busy); else passed++;
        checks++; if (bus.timeout_id !== 2'd2) $display("FAIL stall_id got=%0d exp=2", bus.timeout_id); else passed++;
        nxt();
        set_req(0, 1'b1, 8'h0C, 1'b1);
        set_req(3, 1'b1, 8'h3C, 1'b1);
        @(negedge clk);
        checks++; if (bus.timeout_irq !== 1'b0) $display("FAIL stall_irq_pulse got=%b exp=0", bus.timeout_irq); else passed++;
        nxt();
        @(negedge clk);
        checks++; if (bus.grant !== 4'b1000 || bus.tx_byte !== 8'h3C) $display("FAIL stall_next_owner got=%b/%h exp=1000/3c", bus.grant, bus.tx_byte); else passed++;
        nxt();
        set_req(3, 1'b0, 8'h00, 1'b0);
        nxt();
        @(negedge clk);
        checks++; if (bus.grant !== 4'b0001 || bus.tx_byte !== 8'h0C || bus.timeout_id !== 2'd2) $display("FAIL stall_drain got=%b/%h/%0d exp=0001/0c/2", bus.grant, bus.tx_byte, bus.timeout_id); else passed++;
        nxt();
        clear_inputs();
    endtask

    task automatic test_reset_mid_packet();
        nxt();
        set_req(1, 1'b1, 8'h10, 1'b0);
        nxt();
        @(negedge clk);
        checks++; if (bus.grant !== 4'b0010 || bus.tx_byte !== 8'h10) $display("FAIL rstmid_first got=%b/%h exp=0010/10", bus.grant, bus.tx_byte); else passed++;
        nxt();
        set_req(1, 1'b1, 8'h11, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.transmit !== 1'b1 || bus.tx_byte !== 8'h11) $display("FAIL rstmid_second got=%b/%h exp=1/11", bus.transmit, bus.tx_byte); else passed++;
        nxt();
        rst = 1'b0;
        set_req(0, 1'b1, 8'h0A, 1'b1);
        set_req(1, 1'b1, 8'h12, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0000 || bus.transmit !== 1'b0 ||
            bus.tx_byte !== 8'h00 || bus.timeout_irq !== 1'b0 || bus.timeout_id !== 2'd0)
            $display("FAIL rstmid_outputs got=grant %b busy %b ready %b tx %b byte %h irq %b id %0d exp=all zero",
                     bus.grant, bus.busy, bus.req_ready, bus.transmit, bus.tx_byte, bus.timeout_irq, bus.timeout_id);
        else passed++;
        nxt();
        @(negedge clk);
        checks++; if (bus.grant !== 4'b0001 || bus.tx_byte !== 8'h0A) $display("FAIL rstmid_rr_ptr got=%b/%h exp=0001/0a", bus.grant, bus.tx_byte); else passed++;
        nxt();
        rst = 1'b1;
        clear_inputs();
        nxt();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_byte [8];
        logic [NR-1:0] exp_grant [8];
        int            exp_cyc [8];
        exp_byte  = '{8'h00, 8'h01, 8'h20, 8'h21, 8'h02, 8'h03, 8'h22, 8'h23};
        exp_grant = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0100, 4'b0100};
        exp_cyc   = '{1, 2, 4, 5, 7, 8, 10, 11};
        for (int r = 0; r < NR; r++) begin p_cnt[r] = 0; p_idx[r] = 0; end
        for (int i = 0; i < 4; i++) begin
            p_data[0][i] = 8'(i);        p_last[0][i] = (i % 2 == 1);
            p_data[2][i] = 8'(8'h20 + i); p_last[2][i] = (i % 2 == 1);
        end
        p_cnt[0] = 4; p_cnt[2] = 4;
        rst = 1'b1;
        nxt(); nxt();
        rst = 1'b0;
        run_traffic(16, 1'b0);
        checks++; if (log_n !== 8) $display("FAIL b2b_count got=%0d exp=8", log_n); else passed++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_byte[i] !== exp_byte[i] || log_grant[i] !== exp_grant[i] || log_cyc[i] !== exp_cyc[i])
                $display("FAIL b2b_push%0d got=byte %h grant %b cyc %0d exp=%h/%b/%0d",
                         i, log_byte[i], log_grant[i], log_cyc[i], exp_byte[i], exp_grant[i], exp_cyc[i]);
            else passed++;
        end
    endtask

    task automatic test_fairness();
        for (int r = 0; r < NR; r++) begin
            p_idx[r] = 0;
            p_cnt[r] = 10;
            for (int k = 0; k < 10; k++) begin
                p_data[r][k] = 8'(r * 16 + k);
                p_last[r][k] = 1'b1;
            end
        end
        rst = 1'b1;
        nxt(); nxt();
        rst = 1'b0;
        run_traffic(600, 1'b1);
        checks++; if (log_n !== 40) $display("FAIL fair_count got=%0d exp=40", log_n); else passed++;
        checks++; if (viol !== 0) $display("FAIL fair_overflow got=%0d exp=0", viol); else passed++;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (log_grant[i] !== (4'b0001 << (i % 4)) || log_byte[i] !== 8'((i % 4) * 16 + i / 4))
                $display("FAIL fair_pkt%0d got=grant %b byte %h exp=%b/%h",
                         i, log_grant[i], log_byte[i], 4'b0001 << (i % 4), 8'((i % 4) * 16 + i / 4));
            else passed++;
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic_packet();
        test_fifo_full();
        test_stall_timeout();
        test_reset_mid_packet();
        test_back_to_back();
        test_fairness();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
